// File: rtl/alu_op_sequencer.sv
// Registered ALU-control decoder with valid/ready handshake.
// Multi-cycle R-type ops hold the ALU for MC_LAT cycles before issue.
module alu_op_sequencer #(
    parameter int ALUOP_W = 4,
    parameter int FN_W    = 5,
    parameter int MC_LAT  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         opcode,
    input  logic [FN_W-1:0]    funct,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_mc,
    output logic               alu_start
);

    localparam int CNT_W = $clog2(MC_LAT);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_VALID,
        S_RUN
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ALUOP_W-1:0] op_q;
    logic               mc_q;
    logic               start_q;
    logic               valid_q;

    logic [ALUOP_W-1:0] op_d;
    logic               mc_d;

    always_comb begin
        op_d = '0;
        if (opcode[5]) begin
            op_d = '0;
        end else if (opcode == 6'b000000) begin
            op_d = funct[ALUOP_W-1:0];
        end else if (opcode == 6'b001000 || opcode[5:4] == 2'b01) begin
            op_d = ALUOP_W'(1);
        end else if (opcode == 6'b001001) begin
            op_d = ALUOP_W'(5);
        end
    end

    assign mc_d = (opcode == 6'b000000) && funct[FN_W-1];

    // VALID passes downstream readiness straight through to avoid bubbles
    assign in_ready = !rst &&
                      ((state_q == S_EMPTY) ||
                       (state_q == S_VALID && out_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            cnt_q   <= '0;
            op_q    <= '0;
            mc_q    <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (flush) begin
            state_q <= S_EMPTY;
            cnt_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state_q)
                S_EMPTY, S_VALID: begin
                    if (in_valid && in_ready) begin
                        op_q <= op_d;
                        mc_q <= mc_d;
                        if (mc_d) begin
                            state_q <= S_RUN;
                            cnt_q   <= CNT_W'(MC_LAT - 1);
                            start_q <= 1'b1;
                            valid_q <= 1'b0;
                        end else begin
                            state_q <= S_VALID;
                            valid_q <= 1'b1;
                        end
                    end else if (state_q == S_VALID && out_ready) begin
                        state_q <= S_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (cnt_q == '0) begin
                        state_q <= S_VALID;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_EMPTY;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = valid_q;
    assign alu_op    = op_q;
    assign alu_mc    = mc_q;
    assign alu_start = start_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: default and narrow-latency builds.
module tb_alu_op_sequencer;

    logic clk;
    logic rst;

    logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [5:0] a_opcode;
    logic [4:0] a_funct;
    logic [3:0] a_alu_op;
    logic       a_alu_mc, a_alu_start;

    logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [5:0] b_opcode;
    logic [5:0] b_funct;
    logic [4:0] b_alu_op;
    logic       b_alu_mc, b_alu_start;

    int checks;
    int failures;

    alu_op_sequencer u_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .opcode    (a_opcode),
        .funct     (a_funct),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .alu_op    (a_alu_op),
        .alu_mc    (a_alu_mc),
        .alu_start (a_alu_start)
    );

    alu_op_sequencer #(
        .ALUOP_W (5),
        .FN_W    (6),
        .MC_LAT  (2)
    ) u_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .opcode    (b_opcode),
        .funct     (b_funct),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .alu_op    (b_alu_op),
        .alu_mc    (b_alu_mc),
        .alu_start (b_alu_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] sw_op  [6] = '{6'b100011, 6'b000000, 6'b001000,
                               6'b010010, 6'b001001, 6'b000111};
    logic [4:0] sw_fn  [6] = '{5'b11111, 5'b00110, 5'b11111,
                               5'b10000, 5'b00000, 5'b01111};
    logic [3:0] sw_exp [6] = '{4'h0, 4'h6, 4'h1, 4'h1, 4'h5, 4'h0};

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        a_flush = 0; a_in_valid = 1; a_out_ready = 1;
        a_opcode = 6'b000000; a_funct = 5'b00000;
        b_flush = 0; b_in_valid = 0; b_out_ready = 1;
        b_opcode = '0; b_funct = '0;

        // reset with an op presented
        #1;
        check("rst_in_ready", a_in_ready, 0);
        step();
        step();
        check("rst_in_ready2", a_in_ready, 0);
        check("rst_out_valid", a_out_valid, 0);
        rst = 1'b0;
        a_in_valid = 0;
        step();
        check("rel_out_valid", a_out_valid, 0);
        check("rel_alu_op", a_alu_op, 0);
        check("rel_alu_mc", a_alu_mc, 0);
        check("rel_alu_start", a_alu_start, 0);
        check("rel_in_ready", a_in_ready, 1);

        // decode sweep, back to back
        for (int i = 0; i < 6; i++) begin
            a_in_valid = 1;
            a_opcode = sw_op[i];
            a_funct = sw_fn[i];
            #1;
            check($sformatf("sw%0d_in_ready", i), a_in_ready, 1);
            step();
            check($sformatf("sw%0d_valid", i), a_out_valid, 1);
            check($sformatf("sw%0d_op", i), a_alu_op, sw_exp[i]);
            check($sformatf("sw%0d_mc", i), a_alu_mc, 0);
        end
        a_in_valid = 0;
        step();
        check("sw_drain", a_out_valid, 0);

        // multi-cycle op, MC_LAT=4
        a_in_valid = 1; a_opcode = 6'b000000; a_funct = 5'b10011;
        step();
        a_in_valid = 0;
        check("mc_start", a_alu_start, 1);
        check("mc_rdy1", a_in_ready, 0);
        check("mc_val1", a_out_valid, 0);
        for (int k = 2; k <= 4; k++) begin
            step();
            check($sformatf("mc_start%0d", k), a_alu_start, 0);
            check($sformatf("mc_rdy%0d", k), a_in_ready, 0);
            check($sformatf("mc_val%0d", k), a_out_valid, 0);
        end
        step();
        check("mc_valid", a_out_valid, 1);
        check("mc_op", a_alu_op, 4'h3);
        check("mc_mc", a_alu_mc, 1);
        check("mc_rdy5", a_in_ready, 1);
        step();
        check("mc_drain", a_out_valid, 0);

        // backpressure
        a_in_valid = 1; a_opcode = 6'b001000;
        step();
        check("bp_first", a_alu_op, 4'h1);
        a_opcode = 6'b001001;
        a_out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_rdy%0d", k), a_in_ready, 0);
            step();
            check($sformatf("bp_val%0d", k), a_out_valid, 1);
            check($sformatf("bp_op%0d", k), a_alu_op, 4'h1);
        end
        a_out_ready = 1;
        #1;
        check("bp_rel_rdy", a_in_ready, 1);
        step();
        a_in_valid = 0;
        check("bp_new_val", a_out_valid, 1);
        check("bp_new_op", a_alu_op, 4'h5);
        step();
        check("bp_drain", a_out_valid, 0);

        // flush on second RUN cycle
        a_in_valid = 1; a_opcode = 6'b000000; a_funct = 5'b10011;
        step();
        a_in_valid = 0;
        step();
        a_flush = 1;
        step();
        a_flush = 0;
        check("fl_valid", a_out_valid, 0);
        check("fl_start", a_alu_start, 0);
        check("fl_rdy", a_in_ready, 1);
        step();
        check("fl_stay_empty", a_out_valid, 0);
        a_in_valid = 1; a_opcode = 6'b001001;
        step();
        a_in_valid = 0;
        check("fl_next_val", a_out_valid, 1);
        check("fl_next_op", a_alu_op, 4'h5);
        check("fl_next_mc", a_alu_mc, 0);
        step();

        // flush drops an op presented the same cycle
        a_flush = 1; a_in_valid = 1; a_opcode = 6'b001000;
        step();
        a_flush = 0; a_in_valid = 0;
        check("fl_drop_val", a_out_valid, 0);

        // reset mid-RUN
        a_in_valid = 1; a_opcode = 6'b000000; a_funct = 5'b10011;
        step();
        a_in_valid = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        check("rr_valid", a_out_valid, 0);
        check("rr_start", a_alu_start, 0);
        check("rr_mc", a_alu_mc, 0);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rr_quiet%0d", k), a_out_valid, 0);
        end

        // narrow variant, MC_LAT=2
        b_in_valid = 1; b_opcode = 6'b000000; b_funct = 6'b100101;
        step();
        b_in_valid = 0;
        check("v_start", b_alu_start, 1);
        check("v_val1", b_out_valid, 0);
        step();
        check("v_start2", b_alu_start, 0);
        check("v_val2", b_out_valid, 0);
        step();
        check("v_val3", b_out_valid, 1);
        check("v_op", b_alu_op, 5'b00101);
        check("v_mc", b_alu_mc, 1);
        b_in_valid = 1; b_opcode = 6'b001001;
        #1;
        check("v_rdy", b_in_ready, 1);
        step();
        b_in_valid = 0;
        check("v_i_val", b_out_valid, 1);
        check("v_i_op", b_alu_op, 5'b00101);
        check("v_i_mc", b_alu_mc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
